// File: rtl/ctrl_pkg.sv
// Shared definitions for the control_seq_n step sequencer.
//   state_t    : sequencer states (IDLE, RUN, DONE), STATE_W bits wide
//   onehot_bit : one-hot decode helper; bit 'pos' of the select vector for index 'idx'
package ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Used bit-by-bit so the select width can follow NUM_STEPS without a fixed maximum.
  function automatic logic onehot_bit(input int idx, input int pos);
    return (idx == pos);
  endfunction

endpackage

// File: rtl/control_seq_n_if.sv
// Host/datapath handshake bundle for control_seq_n.
//   start, iter_count, stall, abort                 : host -> sequencer
//   step_sel, step_idx, iter_idx, busy, done, aborted : sequencer -> host/datapath
// master modport is the host side, slave modport is the sequencer.
interface control_seq_n_if #(
  parameter int NUM_STEPS = 3,
  parameter int ITER_W    = 4
);
  localparam int STEP_W = $clog2(NUM_STEPS);

  logic                 start;
  logic [ITER_W-1:0]    iter_count;
  logic                 stall;
  logic                 abort;
  logic [NUM_STEPS-1:0] step_sel;
  logic [STEP_W-1:0]    step_idx;
  logic [ITER_W-1:0]    iter_idx;
  logic                 busy;
  logic                 done;
  logic                 aborted;

  modport master (
    output start, iter_count, stall, abort,
    input  step_sel, step_idx, iter_idx, busy, done, aborted
  );

  modport slave (
    input  start, iter_count, stall, abort,
    output step_sel, step_idx, iter_idx, busy, done, aborted
  );

endinterface

// File: rtl/ctrl_step_counter.sv
// Step/iteration counter pair for the sequencer.
//   clk, rst_n : clock, async active-low reset
//   en         : advance one step (held low while stalled)
//   clr        : synchronous clear of both counters (wins over en)
//   count      : latched iteration count for the run
//   step_q     : current step index      step_nxt : value it takes at the next edge
//   iter_q     : current iteration index
//   step_tc    : step_q is the last phase
//   iter_tc    : iter_q is the last iteration (count-1)
module ctrl_step_counter #(
  parameter int NUM_STEPS = 3,
  parameter int ITER_W    = 4,
  parameter int STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [ITER_W-1:0] count,
  output logic [STEP_W-1:0] step_q,
  output logic [STEP_W-1:0] step_nxt,
  output logic [ITER_W-1:0] iter_q,
  output logic              step_tc,
  output logic              iter_tc
);

  logic [ITER_W-1:0] iter_nxt;

  assign step_tc = (step_q == STEP_W'(NUM_STEPS - 1));
  // Only evaluated while running, where count >= 1, so count-1 never underflows.
  assign iter_tc = (iter_q == count - ITER_W'(1));

  always_comb begin
    step_nxt = step_q;
    iter_nxt = iter_q;
    if (clr) begin
      step_nxt = '0;
      iter_nxt = '0;
    end else if (en) begin
      if (step_tc) begin
        step_nxt = '0;
        iter_nxt = iter_q + ITER_W'(1);
      end else begin
        step_nxt = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      iter_q <= '0;
    end else begin
      step_q <= step_nxt;
      iter_q <= iter_nxt;
    end
  end

endmodule

// File: rtl/control_seq_n.sv
// Parametrised step sequencer: walks a datapath through NUM_STEPS one-hot
// select phases, repeats that iter_count times per run, then pulses done.
//   clk, rst_n : clock, async active-low reset
//   bus        : control_seq_n_if slave (start/iter_count/stall/abort in,
//                step_sel/step_idx/iter_idx/busy/done/aborted out)
// All outputs come straight from flops.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | stepping through phases; step_sel one-hot
// DONE  | one-cycle completion, done=1, step_sel=0
module control_seq_n
  import ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 3,
  parameter int ITER_W    = 4
) (
  input logic             clk,
  input logic             rst_n,
  control_seq_n_if.slave  bus
);

  localparam int STEP_W = $clog2(NUM_STEPS);

  state_t               state_q, state_nxt;
  logic [ITER_W-1:0]    count_q;
  logic                 latch_cnt;
  logic                 cnt_en;
  logic                 cnt_clr;
  logic                 abort_hit;
  logic [STEP_W-1:0]    step_q, step_nxt;
  logic [ITER_W-1:0]    iter_q;
  logic                 step_tc, iter_tc;
  logic [NUM_STEPS-1:0] sel_nxt;
  logic [NUM_STEPS-1:0] step_sel_q;
  logic                 busy_q, done_q, aborted_q;

  always_comb begin
    state_nxt = state_q;
    latch_cnt = 1'b0;
    cnt_en    = 1'b0;
    abort_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          latch_cnt = 1'b1;
          // A zero count skips RUN entirely and still reports completion.
          state_nxt = (bus.iter_count != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          abort_hit = 1'b1;
          state_nxt = IDLE;
        end else if (!bus.stall) begin
          cnt_en = 1'b1;
          if (step_tc && iter_tc) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters sit at zero whenever we are not running, so step_idx/iter_idx
  // need no extra masking and a new run always starts from phase 0.
  assign cnt_clr = (state_nxt != RUN);

  ctrl_step_counter #(
    .NUM_STEPS (NUM_STEPS),
    .ITER_W    (ITER_W),
    .STEP_W    (STEP_W)
  ) u_step_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .count    (count_q),
    .step_q   (step_q),
    .step_nxt (step_nxt),
    .iter_q   (iter_q),
    .step_tc  (step_tc),
    .iter_tc  (iter_tc)
  );

  // Decode from next-state values so step_sel can be a plain flop aligned with step_idx.
  always_comb begin
    sel_nxt = '0;
    if (state_nxt == RUN) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        sel_nxt[i] = onehot_bit(int'(step_nxt), i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      step_sel_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (latch_cnt) count_q <= bus.iter_count;
      step_sel_q <= sel_nxt;
      busy_q     <= (state_nxt != IDLE);
      done_q     <= (state_nxt == DONE);
      aborted_q  <= abort_hit;
    end
  end

  assign bus.step_sel = step_sel_q;
  assign bus.step_idx = step_q;
  assign bus.iter_idx = iter_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;

endmodule

// File: tb/tb_control_seq_n.sv
// Directed, table-driven bench for control_seq_n (NUM_STEPS=3, ITER_W=4).
module tb_control_seq_n;

  localparam int NS = 3;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  control_seq_n_if #(.NUM_STEPS(NS), .ITER_W(IW)) bus ();

  control_seq_n #(.NUM_STEPS(NS), .ITER_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [3:0] cnt;
    logic       stall;
    logic       abort;
    logic [2:0] sel;
    logic [1:0] sidx;
    logic [3:0] iidx;
    logic       busy;
    logic       done;
    logic       abt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] pk(input logic [2:0] s, input logic [1:0] si,
                                     input logic [3:0] ii, input logic b,
                                     input logic d, input logic a);
    return {s, si, ii, b, d, a};
  endfunction

  function automatic logic [11:0] dut_out();
    return pk(bus.step_sel, bus.step_idx, bus.iter_idx, bus.busy, bus.done, bus.aborted);
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got sel=%b idx=%0d iter=%0d busy=%b done=%b aborted=%b, expected sel=%b idx=%0d iter=%0d busy=%b done=%b aborted=%b",
               name, act[11:9], act[8:7], act[6:3], act[2], act[1], act[0],
               exp[11:9], exp[8:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic st, input logic [3:0] cnt, input logic stl, input logic ab,
                     input logic [2:0] sel, input logic [1:0] si, input logic [3:0] ii,
                     input logic bz, input logic dn, input logic abt);
    vec_t v;
    v.start = st;  v.cnt = cnt; v.stall = stl; v.abort = ab;
    v.sel = sel;   v.sidx = si; v.iidx = ii;   v.busy = bz;  v.done = dn; v.abt = abt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [2:0] es;

    rst_n          = 1'b1;
    bus.start      = 1'b0;
    bus.iter_count = '0;
    bus.stall      = 1'b0;
    bus.abort      = 1'b0;

    // count=1: one pass through the three phases
    add(1, 1, 0, 0, 3'b001, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 3'b010, 1, 0, 1, 0, 0);
    add(0, 1, 0, 0, 3'b100, 2, 0, 1, 0, 0);
    add(0, 1, 0, 0, 3'b000, 0, 0, 1, 1, 0);
    add(0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    // count=3, with a start (and a different count) pulsed mid-run
    add(1, 3, 0, 0, 3'b001, 0, 0, 1, 0, 0);
    add(0, 3, 0, 0, 3'b010, 1, 0, 1, 0, 0);
    add(0, 3, 0, 0, 3'b100, 2, 0, 1, 0, 0);
    add(0, 3, 0, 0, 3'b001, 0, 1, 1, 0, 0);
    add(1, 1, 0, 0, 3'b010, 1, 1, 1, 0, 0);
    add(0, 3, 0, 0, 3'b100, 2, 1, 1, 0, 0);
    add(0, 3, 0, 0, 3'b001, 0, 2, 1, 0, 0);
    add(0, 3, 0, 0, 3'b010, 1, 2, 1, 0, 0);
    add(0, 3, 0, 0, 3'b100, 2, 2, 1, 0, 0);
    add(0, 3, 0, 0, 3'b000, 0, 0, 1, 1, 0);
    add(0, 3, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    // count=2, two stall cycles on phase 010
    add(1, 2, 0, 0, 3'b001, 0, 0, 1, 0, 0);
    add(0, 2, 0, 0, 3'b010, 1, 0, 1, 0, 0);
    add(0, 2, 1, 0, 3'b010, 1, 0, 1, 0, 0);
    add(0, 2, 1, 0, 3'b010, 1, 0, 1, 0, 0);
    add(0, 2, 0, 0, 3'b100, 2, 0, 1, 0, 0);
    add(0, 2, 0, 0, 3'b001, 0, 1, 1, 0, 0);
    add(0, 2, 0, 0, 3'b010, 1, 1, 1, 0, 0);
    add(0, 2, 0, 0, 3'b100, 2, 1, 1, 0, 0);
    add(0, 2, 0, 0, 3'b000, 0, 0, 1, 1, 0);
    add(0, 2, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    // count=4, abort (with stall) sampled at the end of the 5th RUN cycle
    add(1, 4, 0, 0, 3'b001, 0, 0, 1, 0, 0);
    add(0, 4, 0, 0, 3'b010, 1, 0, 1, 0, 0);
    add(0, 4, 0, 0, 3'b100, 2, 0, 1, 0, 0);
    add(0, 4, 0, 0, 3'b001, 0, 1, 1, 0, 0);
    add(0, 4, 0, 0, 3'b010, 1, 1, 1, 0, 0);
    add(0, 4, 1, 1, 3'b000, 0, 0, 0, 0, 1);
    add(0, 4, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    add(0, 4, 0, 1, 3'b000, 0, 0, 0, 0, 0);
    // count=0 goes straight to DONE; abort during DONE ignored
    add(1, 0, 0, 0, 3'b000, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    // start held high through DONE re-arms on the first IDLE cycle
    add(1, 1, 0, 0, 3'b001, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 3'b010, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 3'b100, 2, 0, 1, 0, 0);
    add(1, 1, 0, 0, 3'b000, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 3'b001, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 3'b010, 1, 0, 1, 0, 0);
    add(0, 1, 0, 0, 3'b100, 2, 0, 1, 0, 0);
    add(0, 1, 0, 0, 3'b000, 0, 0, 1, 1, 0);
    add(0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0);

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset", dut_out(), 12'h000);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.start      = vecs[i].start;
      bus.iter_count = vecs[i].cnt;
      bus.stall      = vecs[i].stall;
      bus.abort      = vecs[i].abort;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), dut_out(),
               pk(vecs[i].sel, vecs[i].sidx, vecs[i].iidx, vecs[i].busy, vecs[i].done, vecs[i].abt));
    end

    // Asynchronous reset in the middle of a run, then a fresh start.
    @(negedge clk);
    bus.start = 1'b1; bus.iter_count = 4'd3; bus.stall = 1'b0; bus.abort = 1'b0;
    @(posedge clk);
    @(negedge clk) bus.start = 1'b0;
    @(posedge clk);
    #1 check("pre_reset_run", dut_out(), pk(3'b010, 1, 0, 1, 0, 0));
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_out(), 12'h000);
    @(negedge clk);
    rst_n = 1'b1; bus.start = 1'b1; bus.iter_count = 4'd1;
    @(posedge clk);
    #1 check("restart", dut_out(), pk(3'b001, 0, 0, 1, 0, 0));
    @(negedge clk) bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("restart_done", dut_out(), pk(3'b000, 0, 0, 1, 1, 0));
    @(posedge clk);
    #1 check("restart_idle", dut_out(), 12'h000);

    // Largest count: 15 iterations, iter_idx must climb to 14 without wrapping.
    @(negedge clk);
    bus.start = 1'b1; bus.iter_count = 4'd15;
    @(posedge clk);
    #1 check("max_count_k0", dut_out(), pk(3'b001, 0, 0, 1, 0, 0));
    @(negedge clk) bus.start = 1'b0;
    for (int k = 1; k < 45; k++) begin
      @(posedge clk);
      es = 3'b001 << (k % 3);
      #1 check($sformatf("max_count_k%0d", k), dut_out(),
               pk(es, 2'(k % 3), 4'(k / 3), 1, 0, 0));
    end
    @(posedge clk);
    #1 check("max_count_done", dut_out(), pk(3'b000, 0, 0, 1, 1, 0));
    @(posedge clk);
    #1 check("max_count_idle", dut_out(), 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
